// File: rtl/multi_producer_ctrl_if.sv
// Producer/buffer-side signal bundle for multi_producer_ctrl.
// master = the controller, slave = producers, buffer and consumer status.
interface multi_producer_ctrl_if #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]        start;
    logic                       stop;
    logic                       rotate_en;
    logic [CHANNELS-1:0]        ch_valid;
    logic [CHANNELS*DATA_W-1:0] ch_data;
    logic                       buffer_full;
    logic                       buffer_empty;
    logic                       cons_valid;
    logic [CHANNELS-1:0]        ch_en;
    logic                       wr_en;
    logic [DATA_W-1:0]          wr_data;
    logic [SEL_W-1:0]           active_ch;
    logic                       busy;
    logic [1:0]                 state;

    modport master (
        input  start, stop, rotate_en, ch_valid, ch_data,
               buffer_full, buffer_empty, cons_valid,
        output ch_en, wr_en, wr_data, active_ch, busy, state
    );

    modport slave (
        output start, stop, rotate_en, ch_valid, ch_data,
               buffer_full, buffer_empty, cons_valid,
        input  ch_en, wr_en, wr_data, active_ch, busy, state
    );
endinterface

// File: rtl/multi_producer_ctrl.sv
// Selects one of CHANNELS producers into the buffer write port, stalling
// losslessly on buffer full, optionally rotating, and draining before idle.
module multi_producer_ctrl #(
    parameter int CHANNELS   = 2,
    parameter int DATA_W     = 16,
    parameter int ROTATE_LEN = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    multi_producer_ctrl_if.master bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (ROTATE_LEN > 1) ? $clog2(ROTATE_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_WAIT  = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_active_ch, w_active_nxt;
    logic [CNT_W-1:0]    r_word_cnt, w_cnt_nxt;
    logic [CHANNELS-1:0] r_start_q;
    logic                r_stop_q;

    logic [CHANNELS-1:0] w_start_edge;
    logic [CHANNELS-1:0] w_sel_onehot;
    logic [CHANNELS-1:0] w_switch_req;
    logic                w_stop_edge;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_data_sel;

    function automatic logic [SEL_W-1:0] lowest_set(input logic [CHANNELS-1:0] v);
        lowest_set = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = SEL_W'(i);
        end
    endfunction

    assign w_start_edge = bus.start & ~r_start_q;
    assign w_stop_edge  = bus.stop & ~r_stop_q;
    assign w_sel_onehot = CHANNELS'(1) << r_active_ch;
    assign w_switch_req = w_start_edge & ~w_sel_onehot;
    assign w_wr_en      = (r_state == S_RUN) & (|(bus.ch_valid & w_sel_onehot)) & ~bus.buffer_full;

    always_comb begin
        w_data_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_active_ch == SEL_W'(i)) w_data_sel = bus.ch_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_active_ch <= '0;
            r_word_cnt  <= '0;
            r_start_q   <= '0;
            r_stop_q    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_active_ch <= w_active_nxt;
            r_word_cnt  <= w_cnt_nxt;
            r_start_q   <= bus.start;
            r_stop_q    <= bus.stop;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active_ch;
        w_cnt_nxt    = r_word_cnt;

        // Counting/rotation first so a start-edge switch below overrides it.
        if (w_wr_en) begin
            if (r_word_cnt == CNT_W'(ROTATE_LEN - 1)) begin
                w_cnt_nxt = '0;
                if (bus.rotate_en) begin
                    w_active_nxt = (r_active_ch == SEL_W'(CHANNELS - 1)) ? '0
                                                                          : r_active_ch + 1'b1;
                end
            end else begin
                w_cnt_nxt = r_word_cnt + 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (|w_start_edge) begin
                    w_state_nxt  = S_RUN;
                    w_active_nxt = lowest_set(w_start_edge);
                    w_cnt_nxt    = '0;
                end
            end
            S_RUN: begin
                if (w_stop_edge) begin
                    w_state_nxt = S_DRAIN;
                end else if (bus.buffer_full) begin
                    w_state_nxt = S_WAIT;
                end else if (|w_switch_req) begin
                    w_active_nxt = lowest_set(w_switch_req);
                    w_cnt_nxt    = '0;
                end
            end
            S_WAIT: begin
                if (w_stop_edge) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    if (!bus.buffer_full) w_state_nxt = S_RUN;
                    if (|w_switch_req) begin
                        w_active_nxt = lowest_set(w_switch_req);
                        w_cnt_nxt    = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.buffer_empty && !bus.cons_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.ch_en     = (r_state == S_RUN) ? w_sel_onehot : '0;
    assign bus.wr_en     = w_wr_en;
    assign bus.wr_data   = w_wr_en ? w_data_sel : '0;
    assign bus.active_ch = r_active_ch;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.state     = r_state;
endmodule
